pmem_loader: RTL and testbench

Byte-stream program-memory writer: the write-side counterpart to the CPU fetch path's read-only use of program memory. It accepts a framed image over a byte-wide valid/ready interface, packs bytes into 16-bit AVR instruction words (low byte first), writes them sequentially into program memory from address 0, and verifies an 8-bit checksum. While a load is in progress it holds the CPU (`cpu_hold`), so the fetch unit never reads a partially written image. It sits between a host byte source (UART receiver or bench driver) and the program memory write port.

---
 rtl/pmem_loader.sv | 133 +++++++++++++
 tb/tb_pmem_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_loader.sv
// Framed byte-stream loader: packs LEN/payload/CS frames into 16-bit words,
// writes them into program memory from address 0 and holds the CPU while loading.
module pmem_loader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  output logic              pm_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         len_q;
  logic [7:0]          sum_q;
  logic [7:0]          lo_q;
  logic [ADDR_W:0]     wc_q;
  logic                in_ready_q, busy_q, done_q, error_q, hold_q, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;

  logic                take;
  logic                start_ok;
  logic                last_word;
  logic                active_d;
  logic [15:0]         len_n;

  // Next-state decode; outputs are registered from state_d below.
  always_comb begin
    take      = in_valid & in_ready_q;
    start_ok  = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
    len_n     = {in_data, len_q[7:0]};
    last_word = ((16'(wc_q) + 16'd1) == len_q);
    state_d   = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_d = S_LEN_LO;
      S_LEN_LO:  if (take) state_d = S_LEN_HI;
      S_LEN_HI:
        if (take) begin
          if (32'(len_n) > DEPTH)   state_d = S_ERR;
          else if (len_n == 16'd0)  state_d = S_CHECK;
          else                      state_d = S_DATA_LO;
        end
      S_DATA_LO: if (take) state_d = S_DATA_HI;
      S_DATA_HI: if (take) state_d = last_word ? S_CHECK : S_DATA_LO;
      S_CHECK:   if (take) state_d = (in_data == sum_q) ? S_DONE : S_ERR;
      default:   state_d = S_IDLE;
    endcase
    active_d = (state_d == S_LEN_LO) | (state_d == S_LEN_HI) | (state_d == S_DATA_LO) |
               (state_d == S_DATA_HI) | (state_d == S_CHECK);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      sum_q      <= '0;
      lo_q       <= '0;
      wc_q       <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= active_d;
      busy_q     <= active_d;
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERR);
      // Hold stays up through ERR so the CPU never runs a bad image.
      hold_q     <= active_d | (state_d == S_ERR);
      we_q       <= 1'b0;
      if (start_ok) begin
        sum_q <= '0;
        wc_q  <= '0;
        len_q <= '0;
      end
      if (take) begin
        case (state_q)
          S_LEN_LO: begin
            len_q[7:0] <= in_data;
            sum_q      <= sum_q + in_data;
          end
          S_LEN_HI: begin
            len_q[15:8] <= in_data;
            sum_q       <= sum_q + in_data;
          end
          S_DATA_LO: begin
            lo_q  <= in_data;
            sum_q <= sum_q + in_data;
          end
          S_DATA_HI: begin
            we_q    <= 1'b1;
            addr_q  <= wc_q[ADDR_W-1:0];
            wdata_q <= {in_data, lo_q};
            wc_q    <= wc_q + (ADDR_W+1)'(1);
            sum_q   <= sum_q + in_data;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_hold   = hold_q;
  assign pm_we      = we_q;
  assign pm_addr    = addr_q;
  assign pm_wdata   = wdata_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Scoreboard bench for pmem_loader: expected writes queued at stimulus time,
// popped and compared on every pm_we pulse; end-of-frame status checked directly.
module tb_pmem_loader;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 512;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] pm_addr;
  logic [15:0]       pm_wdata;
  logic              pm_we;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  wr_t  exp_q[$];
  logic [7:0]  frame[$];
  logic [15:0] mem [DEPTH];
  logic        prev_we = 1'b0;

  pmem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .pm_we(pm_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Write monitor: every strobe must match the next expected write.
  always @(negedge CLK) begin
    if (pm_we) begin
      check("we_single_cycle", 32'(prev_we), 32'd0);
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(pm_addr), 32'(e.addr));
        check("wr_data", 32'(pm_wdata), 32'(e.data));
      end
      mem[pm_addr] = pm_wdata;
    end
    prev_we = pm_we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_hold", 32'(cpu_hold), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("ready_timeout", 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic send_frame(input bit throttle);
    foreach (frame[i]) send_byte(frame[i], throttle ? int'($urandom_range(1, 5)) : 0);
    in_valid = 1'b0;
  endtask

  // Random n-word frame; expected writes are queued here.
  task automatic build_frame(input int n, input bit bad_cs);
    logic [7:0]  cs;
    logic [15:0] w;
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      frame.push_back(w[7:0]);
      frame.push_back(w[15:8]);
      exp_q.push_back('{addr: ADDR_W'(i), data: w});
    end
    cs = '0;
    foreach (frame[i]) cs = cs + frame[i];
    frame.push_back(bad_cs ? cs + 8'd1 : cs);
  endtask

  task automatic check_end(input string tag, input bit d, input bit e, input bit h, input int wc);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(h));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wc"}, 32'(word_count), 32'(wc));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(pm_we), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_addr"}, 32'(pm_addr), 32'd0);
    check({tag, "_wdata"}, 32'(pm_wdata), 32'd0);
    check({tag, "_wc"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    RST = 1'b0;
    check_reset("rst");

    // Two-word image from the datasheet example.
    do_start();
    frame = '{8'h02, 8'h00, 8'h0C, 8'h94, 8'h00, 8'h00, 8'hA2};
    exp_q.push_back('{addr: 9'd0, data: 16'h940C});
    exp_q.push_back('{addr: 9'd1, data: 16'h0000});
    send_frame(1'b0);
    check_end("two_word", 1'b1, 1'b0, 1'b0, 2);
    check("fetch_pc0", 32'(mem[0]), 32'h940C);

    // Bad checksum: words still land, hold stays up.
    do_start();
    frame = '{8'h02, 8'h00, 8'h0C, 8'h94, 8'h00, 8'h00, 8'hA3};
    exp_q.push_back('{addr: 9'd0, data: 16'h940C});
    exp_q.push_back('{addr: 9'd1, data: 16'h0000});
    send_frame(1'b0);
    check_end("bad_cs", 1'b0, 1'b1, 1'b1, 2);

    // Zero-length frame.
    do_start();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    check_end("zero_len", 1'b1, 1'b0, 1'b0, 0);

    // Oversize length aborts right after LEN_HI.
    do_start();
    frame = '{8'h01, 8'h02};
    send_frame(1'b0);
    check_end("oversize", 1'b0, 1'b1, 1'b1, 0);
    check("oversize_busy", 32'(busy), 32'd0);
    do_start();
    build_frame(3, 1'b0);
    send_frame(1'b0);
    check_end("after_oversize", 1'b1, 1'b0, 1'b0, 3);

    // Throttled source, same two-word frame.
    do_start();
    frame = '{8'h02, 8'h00, 8'h0C, 8'h94, 8'h00, 8'h00, 8'hA2};
    exp_q.push_back('{addr: 9'd0, data: 16'h940C});
    exp_q.push_back('{addr: 9'd1, data: 16'h0000});
    send_frame(1'b1);
    check_end("throttled", 1'b1, 1'b0, 1'b0, 2);

    // start during DATA_LO must be ignored.
    do_start();
    build_frame(1, 1'b0);
    send_byte(frame[0], 0);
    send_byte(frame[1], 0);
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ign_start_busy", 32'(busy), 32'd1);
    for (int i = 2; i < 5; i++) send_byte(frame[i], 0);
    in_valid = 1'b0;
    check_end("ign_start", 1'b1, 1'b0, 1'b0, 1);

    // Reset after the third payload byte.
    mem[1] = 16'hDEAD;
    do_start();
    exp_q.push_back('{addr: 9'd0, data: 16'h940C});
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h0C, 0);
    send_byte(8'h94, 0);
    send_byte(8'h00, 0);
    in_valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_reset("mid_rst");
    repeat (4) tick();
    check("mid_rst_idle_busy", 32'(busy), 32'd0);
    check("mid_rst_addr0", 32'(mem[0]), 32'h940C);
    check("mid_rst_addr1", 32'(mem[1]), 32'hDEAD);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
